// File: rtl/clk_2hz_if.sv
// Enable/strobe bundle between the slow-clock divider and its consumers.
interface clk_2hz_if;
  logic en;
  logic flash;
  logic tick;

  // Consumer side: drives the enable, observes the square wave and strobe.
  modport master (
    output en,
    input  flash,
    input  tick
  );

  // Divider side.
  modport slave (
    input  en,
    output flash,
    output tick
  );
endinterface : clk_2hz_if

// File: rtl/clk_2hz.sv
// Slow square-wave enable generator for game-state stepping.
// flash toggles every HALF_PERIOD enabled cycles; tick strobes on each flash rise.
module clk_2hz #(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned OUT_FREQ_HZ = 2
) (
  input  logic       clk,
  input  logic       RSTN,
  clk_2hz_if.slave   bus
);

  localparam int unsigned HALF_PERIOD = CLK_FREQ_HZ / (2 * OUT_FREQ_HZ);
  localparam int unsigned CNT_W       = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int unsigned CNT_MAX     = (HALF_PERIOD > 0) ? HALF_PERIOD - 1 : 0;

  // Reject a divider that cannot produce even one cycle per half-period.
  if (HALF_PERIOD < 1) begin : g_bad_half_period
    $error("clk_2hz: HALF_PERIOD must be at least 1");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flash_q, flash_d;
  logic             tick_q, tick_d;

  // Next-state: count enabled cycles, toggle flash on wrap, strobe on 0->1.
  always_comb begin
    cnt_d   = cnt_q;
    flash_d = flash_q;
    tick_d  = 1'b0;
    if (bus.en) begin
      if (cnt_q == CNT_W'(CNT_MAX)) begin
        cnt_d   = '0;
        flash_d = ~flash_q;
        tick_d  = ~flash_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!RSTN) begin
      cnt_q   <= '0;
      flash_q <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      flash_q <= flash_d;
      tick_q  <= tick_d;
    end
  end

  assign bus.flash = flash_q;
  assign bus.tick  = tick_q;

endmodule : clk_2hz

// File: tb/tb_clk_2hz.sv
// Checks two divider instances (HALF_PERIOD=5 and HALF_PERIOD=1) against an
// enabled-cycle-count model: after n enabled cycles since reset,
// cnt = n mod HP, flash = (n / HP) mod 2, and tick follows an enabled cycle
// that lands on n mod 2HP == HP.
module tb_clk_2hz;

  localparam int HP_A = 5;
  localparam int HP_B = 1;

  logic clk;
  logic rstn;
  int   total;
  int   bad;
  int   n_en;
  logic last_en;
  logic last_rst;

  clk_2hz_if bus_a ();
  clk_2hz_if bus_b ();

  clk_2hz #(.CLK_FREQ_HZ(20), .OUT_FREQ_HZ(2)) u_dut_a (
    .clk  (clk),
    .RSTN (rstn),
    .bus  (bus_a)
  );

  clk_2hz #(.CLK_FREQ_HZ(4), .OUT_FREQ_HZ(2)) u_dut_b (
    .clk  (clk),
    .RSTN (rstn),
    .bus  (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Compare both instances with the model state after the latest edge.
  task automatic check_all(input string tag);
    int exp_cnt_a, exp_fl_a, exp_tk_a;
    int exp_fl_b, exp_tk_b;
    exp_cnt_a = n_en % HP_A;
    exp_fl_a  = (n_en / HP_A) % 2;
    exp_tk_a  = (last_rst && last_en && (n_en % (2 * HP_A) == HP_A)) ? 1 : 0;
    exp_fl_b  = (n_en / HP_B) % 2;
    exp_tk_b  = (last_rst && last_en && (n_en % (2 * HP_B) == HP_B)) ? 1 : 0;
    chk({tag, "_a_flash"}, int'(bus_a.flash), exp_fl_a);
    chk({tag, "_a_tick"},  int'(bus_a.tick),  exp_tk_a);
    chk({tag, "_a_cnt"},   int'(u_dut_a.cnt_q), exp_cnt_a);
    chk({tag, "_b_flash"}, int'(bus_b.flash), exp_fl_b);
    chk({tag, "_b_tick"},  int'(bus_b.tick),  exp_tk_b);
  endtask

  // One clock with the given reset/enable, then model update and check.
  task automatic step(input logic r, input logic e, input string tag);
    rstn     = r;
    bus_a.en = e;
    bus_b.en = e;
    @(posedge clk);
    #1;
    last_rst = r;
    last_en  = e;
    if (!r)     n_en = 0;
    else if (e) n_en = n_en + 1;
    check_all(tag);
    @(negedge clk);
  endtask

  initial begin
    int rise_at;
    total    = 0;
    bad      = 0;
    n_en     = 0;
    last_en  = 1'b0;
    last_rst = 1'b0;
    rstn     = 1'b0;
    bus_a.en = 1'b0;
    bus_b.en = 1'b0;
    @(negedge clk);

    // Reset held 3 cycles with en=1: outputs stay low.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, "rst");

    // Release: first rise exactly 5 cycles later, tick for that cycle only.
    rise_at = -1;
    for (int k = 1; k <= 12; k++) begin
      step(1'b1, 1'b1, "rel");
      if (bus_a.tick === 1'b1 && rise_at < 0) rise_at = k;
    end
    chk("first_rise_cycle", rise_at, 5);

    // Free run 40 cycles: period 10, 50% duty, one tick per period.
    begin
      int hi_cnt, tk_cnt;
      hi_cnt = 0;
      tk_cnt = 0;
      for (int k = 0; k < 40; k++) begin
        step(1'b1, 1'b1, "run");
        if (bus_a.flash === 1'b1) hi_cnt++;
        if (bus_a.tick === 1'b1)  tk_cnt++;
      end
      chk("run_high_cycles", hi_cnt, 20);
      chk("run_ticks", tk_cnt, 4);
    end

    // Advance to cnt=2, freeze 7 cycles, resume: toggle 3 cycles later.
    while ((n_en % HP_A) != 2) step(1'b1, 1'b1, "seek2");
    for (int k = 0; k < 7; k++) step(1'b1, 1'b0, "hold");
    begin
      int fl0, toggle_at;
      fl0 = int'(bus_a.flash);
      toggle_at = -1;
      for (int k = 1; k <= 5; k++) begin
        step(1'b1, 1'b1, "resume");
        if (int'(bus_a.flash) != fl0 && toggle_at < 0) toggle_at = k;
      end
      chk("resume_toggle_cycle", toggle_at, 3);
    end

    // Reach flash=1 with cnt=3, then a single-cycle reset.
    while ((n_en % (2 * HP_A)) != 8) step(1'b1, 1'b1, "seek8");
    chk("pre_rst_flash", int'(bus_a.flash), 1);
    step(1'b0, 1'b1, "rst1");
    chk("post_rst_cnt", int'(u_dut_a.cnt_q), 0);
    begin
      int rise2;
      rise2 = -1;
      for (int k = 1; k <= 8; k++) begin
        step(1'b1, 1'b1, "rel2");
        if (bus_a.tick === 1'b1 && rise2 < 0) rise2 = k;
      end
      chk("restart_rise_cycle", rise2, 5);
    end

    // Randomized enable with occasional resets.
    for (int k = 0; k < 400; k++) begin
      logic r, e;
      r = ($urandom_range(0, 99) >= 3);
      e = ($urandom_range(0, 99) < 75);
      step(r, e, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_clk_2hz
